// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 16;
   localparam int unsigned MIN_DIV   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

endpackage

// File: rtl/div_counter.sv
// Period counter for the divider: counts 0..div-1, flags the wrap edge and
// produces the registered clk_out level plus the per-period tick.
module div_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_run,
   input  logic             i_stop,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_wrap,
   output logic             o_clk_out,
   output logic             o_tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_tick;

   logic [DIV_W-1:0] w_cnt_inc;
   logic [DIV_W-1:0] w_half;
   logic             w_wrap;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic             w_clk_nxt;
   logic             w_tick_nxt;

   assign w_cnt_inc = r_cnt + ONE;
   assign w_half    = i_div >> 1;
   assign w_wrap    = i_run && (r_cnt == (i_div - ONE));

   always_comb begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = 1'b0;
      w_tick_nxt = 1'b0;
      if (i_start) begin
         // First period after leaving idle: high immediately, no tick.
         w_clk_nxt = 1'b1;
      end else if (i_run) begin
         if (w_wrap) begin
            w_clk_nxt  = !i_stop;
            w_tick_nxt = !i_stop;
         end else begin
            w_cnt_nxt = w_cnt_inc;
            w_clk_nxt = (w_cnt_inc < w_half);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_clk_out <= w_clk_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   assign o_wrap    = w_wrap;
   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: start/stop sequencing and ratio reprogramming,
// with all changes deferred to a period boundary.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] cur_div,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
);

   state_e           r_state;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pend;
   logic             r_cfg_err;

   state_e           w_state_nxt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [DIV_W-1:0] w_pend_nxt;
   logic             w_ready;
   logic             w_xfer;
   logic             w_good;
   logic             w_wrap;

   assign w_ready = (r_state != ST_PEND);
   assign w_xfer  = cfg_valid && w_ready;
   assign w_good  = (cfg_div >= DIV_W'(MIN_DIV));

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_pend_nxt  = r_pend;
      unique case (r_state)
         ST_IDLE: begin
            if (w_xfer && w_good) w_div_nxt = cfg_div;
            if (en) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_wrap && !en) begin
               // Stopping at this edge: nothing left to defer the ratio to.
               w_state_nxt = ST_IDLE;
               if (w_xfer && w_good) w_div_nxt = cfg_div;
            end else if (w_xfer && w_good) begin
               w_pend_nxt  = cfg_div;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            if (w_wrap) begin
               w_div_nxt   = r_pend;
               w_state_nxt = en ? ST_RUN : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_div     <= DIV_W'(DEFAULT_DIV);
         r_pend    <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_pend    <= w_pend_nxt;
         r_cfg_err <= w_xfer && !w_good;
      end
   end

   div_counter #(
      .DIV_W (DIV_W)
   ) u_div_counter (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .i_start   ((r_state == ST_IDLE) && en),
      .i_run     (r_state != ST_IDLE),
      .i_stop    (!en),
      .i_div     (r_div),
      .o_wrap    (w_wrap),
      .o_clk_out (clk_out),
      .o_tick    (tick)
   );

   assign cfg_ready = w_ready;
   assign cfg_err   = r_cfg_err;
   assign cur_div   = r_div;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: vector table, directed corner sequences and a
// random run against a period/phase reference model.
module tb_clk_div_ctrl;

   localparam int DW = 16;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic          en;
   logic          cfg_valid;
   logic [DW-1:0] cfg_div;
   logic          cfg_ready;
   logic          cfg_err;
   logic [DW-1:0] cur_div;
   logic          clk_out;
   logic          tick;
   logic          busy;

   always #5 clk_in = ~clk_in;

   clk_div_ctrl #(
      .DIV_W       (DW),
      .DEFAULT_DIV (4)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .cur_div   (cur_div),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic check_all(input string tag, input int e_clk, input int e_tick,
                            input int e_busy, input int e_rdy, input int e_cur,
                            input int e_err);
      check({tag, ".clk_out"},   int'(clk_out),   e_clk);
      check({tag, ".tick"},      int'(tick),      e_tick);
      check({tag, ".busy"},      int'(busy),      e_busy);
      check({tag, ".cfg_ready"}, int'(cfg_ready), e_rdy);
      check({tag, ".cur_div"},   int'(cur_div),   e_cur);
      check({tag, ".cfg_err"},   int'(cfg_err),   e_err);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   // Reference model: divider seen as a phase within a period of m_div cycles.
   bit m_run, m_first;
   int m_phase, m_div, m_pend, m_err;

   function automatic void model_reset();
      m_run = 0; m_first = 0; m_phase = 0; m_div = 4; m_pend = -1; m_err = 0;
   endfunction

   function automatic bit model_ready();
      return !(m_run && m_pend >= 0);
   endfunction

   function automatic void model_step(input bit e, input bit v, input int d);
      int  old_pend = m_pend;
      bit  xfer     = v && model_ready();
      bit  good     = (d >= 2);
      m_err = (xfer && !good) ? 1 : 0;
      if (!m_run) begin
         if (xfer && good) m_div = d;
         if (e) begin
            m_run = 1; m_phase = 0; m_first = 1;
         end
      end else if (m_phase == m_div - 1) begin
         if (old_pend >= 0) begin
            m_div  = old_pend;
            m_pend = -1;
         end
         m_phase = 0;
         if (!e) begin
            m_run = 0;
            if (xfer && good) m_div = d;
         end else begin
            m_first = 0;
            if (xfer && good) m_pend = d;
         end
      end else begin
         m_phase++;
         if (xfer && good) m_pend = d;
      end
   endfunction

   task automatic model_compare(input string tag);
      check_all(tag, int'(m_run && (m_phase < m_div / 2)),
                int'(m_run && m_phase == 0 && !m_first), int'(m_run),
                int'(model_ready()), m_div, m_err);
   endtask

   typedef struct {
      bit en; bit v; int d;
      bit clk; bit tk; bit bsy; bit rdy; int cur; bit err;
   } vec_t;

   vec_t tbl[21];

   initial begin
      // Start N=4, reprogram to 6 mid-period, then reject a ratio of 1.
      tbl[0]  = '{1, 0, 0, 1, 0, 1, 1, 4, 0};
      tbl[1]  = '{1, 0, 0, 1, 0, 1, 1, 4, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 1, 1, 4, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 1, 1, 4, 0};
      tbl[4]  = '{1, 0, 0, 1, 1, 1, 1, 4, 0};
      tbl[5]  = '{1, 0, 0, 1, 0, 1, 1, 4, 0};
      tbl[6]  = '{1, 1, 6, 0, 0, 1, 0, 4, 0};
      tbl[7]  = '{1, 0, 0, 0, 0, 1, 0, 4, 0};
      tbl[8]  = '{1, 0, 0, 1, 1, 1, 1, 6, 0};
      tbl[9]  = '{1, 0, 0, 1, 0, 1, 1, 6, 0};
      tbl[10] = '{1, 0, 0, 1, 0, 1, 1, 6, 0};
      tbl[11] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[12] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[13] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[14] = '{1, 0, 0, 1, 1, 1, 1, 6, 0};
      tbl[15] = '{1, 1, 1, 1, 0, 1, 1, 6, 1};
      tbl[16] = '{1, 0, 0, 1, 0, 1, 1, 6, 0};
      tbl[17] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[18] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[19] = '{1, 0, 0, 0, 0, 1, 1, 6, 0};
      tbl[20] = '{1, 0, 0, 1, 1, 1, 1, 6, 0};

      do_reset();
      check_all("reset", 0, 0, 0, 1, 4, 0);

      for (int i = 0; i < 21; i++) begin
         en        = tbl[i].en;
         cfg_valid = tbl[i].v;
         cfg_div   = DW'(tbl[i].d);
         step();
         check_all($sformatf("vec%0d", i), int'(tbl[i].clk), int'(tbl[i].tk),
                   int'(tbl[i].bsy), int'(tbl[i].rdy), tbl[i].cur, int'(tbl[i].err));
      end

      // Stop requested at cnt=1 with N=4: two more cycles, then idle.
      do_reset();
      en = 1'b1;
      step();
      step();
      en = 1'b0;
      step();
      check_all("stop.c2", 0, 0, 1, 1, 4, 0);
      step();
      check_all("stop.c3", 0, 0, 1, 1, 4, 0);
      step();
      check_all("stop.idle", 0, 0, 0, 1, 4, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("stop.quiet%0d.tick", k), int'(tick), 0);
         check($sformatf("stop.quiet%0d.clk", k), int'(clk_out), 0);
      end

      // N=5 written in idle on the same cycle as en=1.
      cfg_valid = 1'b1;
      cfg_div   = DW'(5);
      en        = 1'b1;
      step();
      cfg_valid = 1'b0;
      check("n5.cur_div", int'(cur_div), 5);
      for (int k = 0; k < 11; k++) begin
         if (k > 0) step();
         check($sformatf("n5.p%0d.clk", k), int'(clk_out), int'((k % 5) < 2));
         check($sformatf("n5.p%0d.tick", k), int'(tick), int'(k > 0 && (k % 5) == 0));
      end

      // Asynchronous reset at cnt=2 with N=6, then restart.
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = DW'(6);
      en        = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
      check("rst6.pre.clk", int'(clk_out), 1);
      #2 rst_n = 1'b0;
      #1;
      check_all("rst6.async", 0, 0, 0, 1, 4, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         check($sformatf("rst6.r%0d.clk", k), int'(clk_out), int'((k % 4) < 2));
         check($sformatf("rst6.r%0d.tick", k), int'(tick), int'(k > 0 && (k % 4) == 0));
      end

      // Random traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 800; c++) begin
         en        = ($urandom_range(0, 15) != 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_div   = DW'($urandom_range(0, 9));
         model_step(en, cfg_valid, int'(cfg_div));
         step();
         model_compare($sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
